time_syn_rx: RTL and testbench
==============================

TIME_SYN_RX -- requirements
Module: time_syn_rx

Interface
REQ-001 SHALL have parameter P_FRAME_LEN, default 8, meaning beats per sync frame (min 2).
REQ-002 SHALL have port i_clk  input  1  clock; all logic on its rising edge.
REQ-003 SHALL have port i_rst  input  1  reset, asynchronous, active-high.
REQ-004 SHALL have port i_local_time  input  64  free-running local time, sampled at frame start.
REQ-005 SHALL have port i_rx_axis_tvalid  input  1  AXIS beat valid.
REQ-006 SHALL have port i_rx_axis_tdata  input  64  AXIS beat data.
REQ-007 SHALL have port i_rx_axis_tlast  input  1  last beat of frame.
REQ-008 SHALL have port i_rx_axis_tkeep  input  8  byte enables; 8'hFF required on every beat.
REQ-009 SHALL have port i_rx_axis_tuser  input  1  MAC error flag, sampled on last beat.
REQ-010 SHALL have port o_rx_axis_tready  output  1  AXIS ready.
REQ-011 SHALL have port o_ts_valid  output  1  one-cycle pulse: peer local-time frame (preamble 64'h66) received.
REQ-012 SHALL have port o_std_valid  output  1  one-cycle pulse: standard-time frame (preamble 64'h88) received.
REQ-013 SHALL have port o_return_valid  output  1  one-cycle pulse: return frame (preamble 64'h55) received.
REQ-014 SHALL have port o_rx_ts  output  64  timestamp carried in beat 1 of the last good frame.
REQ-015 SHALL have port o_rx_local_time  output  64  i_local_time sampled on beat 0 of the last good frame.
REQ-016 SHALL have port o_err_cnt  output  16  count of rejected frames, saturating.

Function
REQ-017 SHALL accept a beat when i_rx_axis_tvalid and o_rx_axis_tready are both 1; tready SHALL be 1 in every cycle after reset release.
REQ-018 SHALL run FSM states IDLE, HDR, BODY, DROP:
- IDLE: accepted beat with tdata equal to 64'h66, 64'h88 or 64'h55 (full 64-bit compare) and tkeep=FF -> HDR; latch type and i_local_time.
- IDLE: any other accepted beat -> DROP.
- HDR: accepted beat latches tdata as candidate timestamp -> BODY.
- BODY: counts beats up to P_FRAME_LEN-1 -> IDLE on tlast.
- DROP: discards beats -> IDLE on the accepted tlast beat.
REQ-019 SHALL hold a beat counter: 0 at frame start, +1 per accepted beat, cleared on the accepted tlast beat.
REQ-020 SHALL deem a frame good only if all hold:
- tlast is on beat P_FRAME_LEN-1 exactly;
- tkeep=FF on every beat;
- tuser=0 on the last beat.
REQ-021 SHALL, for a good frame, in the cycle after the tlast beat is accepted, pulse exactly one type valid for one cycle and update o_rx_ts and o_rx_local_time in that same cycle.
REQ-022 SHALL hold o_rx_ts and o_rx_local_time stable between good frames; bad frames SHALL NOT modify them.
REQ-023 SHALL treat tlast before beat P_FRAME_LEN-1 as a bad frame and return to IDLE.
REQ-024 SHALL treat a missing tlast on beat P_FRAME_LEN-1 as a bad frame and go to DROP until tlast.
REQ-025 SHALL treat a tlast on beat 0 in IDLE as a one-beat bad frame and stay in IDLE.
REQ-026 SHALL increment o_err_cnt by 1 per bad frame, one cycle after the terminating beat; DROP SHALL count once per frame; the count SHALL saturate at 16'hFFFF.
REQ-027 SHALL leave state and counter unchanged while tvalid=0; bubbles within a frame are legal.
REQ-028 SHALL pipeline back-to-back frames: a new beat 0 may arrive in the cycle the previous result pulses.

Reset
REQ-029 SHALL, on i_rst, force FSM to IDLE and beat counter to 0 immediately.
REQ-030 SHALL, on i_rst, force o_rx_axis_tready=0, all valid pulses 0, o_rx_ts=0, o_rx_local_time=0, o_err_cnt=0.
REQ-031 SHALL, on reset asserted mid-frame, discard the partial frame with no valid pulse; the remainder arriving after release SHALL be handled per REQ-018 (typically DROP, error +1).

Verification
REQ-032 Good ts frame: beats 66, 0x1234, 6x don't-care, tlast on beat 7, i_local_time=0x500 at beat 0 -> o_ts_valid 1 cycle, o_rx_ts=0x1234, o_rx_local_time=0x500, o_err_cnt=0.
REQ-033 Back-to-back 88 then 55 frames, no gap, random tvalid bubbles -> o_std_valid then o_return_valid, each with its own timestamp, no lost frame.
REQ-034 Unknown preamble 0x77, 8 beats -> no pulse, o_err_cnt=1, next good frame accepted.
REQ-035 Length errors: tlast on beat 5; then a 10-beat frame -> no pulses, o_err_cnt=2, outputs unchanged from the prior good frame.
REQ-036 tuser=1 on the last beat of a good-format 66 frame -> no pulse, o_err_cnt +1; tkeep=0F on beat 3 -> no pulse, o_err_cnt +1.
REQ-037 i_rst asserted on beat 3, released, remaining beats 4-7 sent, then a good frame -> no pulse for the partial frame, o_err_cnt=1, good frame pulses normally; separately, forcing o_err_cnt to 0xFFFF plus one bad frame -> count stays 0xFFFF.

Source files
------------

// File: rtl/time_syn_rx.sv
// Time-sync frame receiver: classifies AXIS sync frames by preamble, validates
// their length and sideband, and publishes the carried timestamp plus the local capture time.
module time_syn_rx #(
  parameter int P_FRAME_LEN = 8
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [63:0] i_local_time,
  input  logic        i_rx_axis_tvalid,
  input  logic [63:0] i_rx_axis_tdata,
  input  logic        i_rx_axis_tlast,
  input  logic [7:0]  i_rx_axis_tkeep,
  input  logic        i_rx_axis_tuser,
  output logic        o_rx_axis_tready,
  output logic        o_ts_valid,
  output logic        o_std_valid,
  output logic        o_return_valid,
  output logic [63:0] o_rx_ts,
  output logic [63:0] o_rx_local_time,
  output logic [15:0] o_err_cnt
);

  localparam int CW = (P_FRAME_LEN > 2) ? $clog2(P_FRAME_LEN) : 1;
  localparam logic [CW-1:0] LAST_IDX = CW'(P_FRAME_LEN - 1);
  localparam logic [63:0] PRE_TS  = 64'h0000_0000_0000_0066;
  localparam logic [63:0] PRE_STD = 64'h0000_0000_0000_0088;
  localparam logic [63:0] PRE_RET = 64'h0000_0000_0000_0055;

  typedef enum logic [1:0] {IDLE = 2'd0, HDR = 2'd1, BODY = 2'd2, DROP = 2'd3} state_t;
  typedef enum logic [1:0] {T_TS = 2'd0, T_STD = 2'd1, T_RET = 2'd2} ftype_t;

  state_t      state_q, state_d;
  ftype_t      type_q, type_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [63:0] cand_ts_q, cand_ts_d;
  logic [63:0] cand_lt_q, cand_lt_d;
  logic        keep_bad_q, keep_bad_d;
  logic        tready_q;
  logic        ts_valid_q, std_valid_q, ret_valid_q;
  logic [63:0] rx_ts_q, rx_lt_q;
  logic [15:0] err_cnt_q;

  logic accept_s, keep_ok_s, pre_hit_s, last_idx_s, keep_bad_nxt_s;
  logic good_s, bad_s;
  ftype_t pre_type_s;

  assign accept_s       = i_rx_axis_tvalid & tready_q;
  assign keep_ok_s      = (i_rx_axis_tkeep == 8'hFF);
  assign last_idx_s     = (cnt_q == LAST_IDX);
  assign keep_bad_nxt_s = keep_bad_q | ~keep_ok_s;

  // Preamble decode: full 64-bit compare against the three frame types
  always_comb begin
    pre_hit_s  = 1'b1;
    pre_type_s = T_TS;
    if (i_rx_axis_tdata == PRE_TS) begin
      pre_type_s = T_TS;
    end else if (i_rx_axis_tdata == PRE_STD) begin
      pre_type_s = T_STD;
    end else if (i_rx_axis_tdata == PRE_RET) begin
      pre_type_s = T_RET;
    end else begin
      pre_hit_s = 1'b0;
    end
  end

  // Frame FSM next-state, beat counter and per-frame verdict
  always_comb begin
    state_d    = state_q;
    type_d     = type_q;
    cnt_d      = cnt_q;
    cand_ts_d  = cand_ts_q;
    cand_lt_d  = cand_lt_q;
    keep_bad_d = keep_bad_q;
    good_s     = 1'b0;
    bad_s      = 1'b0;
    if (accept_s) begin
      case (state_q)
        IDLE: begin
          if (i_rx_axis_tlast) begin
            bad_s = 1'b1;
            cnt_d = '0;
          end else if (pre_hit_s && keep_ok_s) begin
            state_d    = HDR;
            type_d     = pre_type_s;
            cand_lt_d  = i_local_time;
            keep_bad_d = 1'b0;
            cnt_d      = CW'(1);
          end else begin
            state_d = DROP;
            cnt_d   = CW'(1);
          end
        end
        HDR, BODY: begin
          if (state_q == HDR) begin
            cand_ts_d = i_rx_axis_tdata;
          end else begin
            cand_ts_d = cand_ts_q;
          end
          keep_bad_d = keep_bad_nxt_s;
          if (i_rx_axis_tlast) begin
            state_d = IDLE;
            cnt_d   = '0;
            if (last_idx_s && !keep_bad_nxt_s && !i_rx_axis_tuser) begin
              good_s = 1'b1;
            end else begin
              bad_s = 1'b1;
            end
          end else if (last_idx_s) begin
            // Overlong frame: error is charged once when DROP sees tlast
            state_d = DROP;
          end else begin
            state_d = BODY;
            cnt_d   = cnt_q + CW'(1);
          end
        end
        DROP: begin
          if (i_rx_axis_tlast) begin
            state_d = IDLE;
            cnt_d   = '0;
            bad_s   = 1'b1;
          end else if (last_idx_s) begin
            cnt_d = cnt_q;
          end else begin
            cnt_d = cnt_q + CW'(1);
          end
        end
        default: begin
          state_d = IDLE;
          cnt_d   = '0;
        end
      endcase
    end else begin
      state_d = state_q;
    end
  end

  // State, counter and candidate registers
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      state_q    <= IDLE;
      type_q     <= T_TS;
      cnt_q      <= '0;
      cand_ts_q  <= 64'd0;
      cand_lt_q  <= 64'd0;
      keep_bad_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      type_q     <= type_d;
      cnt_q      <= cnt_d;
      cand_ts_q  <= cand_ts_d;
      cand_lt_q  <= cand_lt_d;
      keep_bad_q <= keep_bad_d;
    end
  end

  // Registered results: pulses, published timestamps, saturating error count
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      tready_q    <= 1'b0;
      ts_valid_q  <= 1'b0;
      std_valid_q <= 1'b0;
      ret_valid_q <= 1'b0;
      rx_ts_q     <= 64'd0;
      rx_lt_q     <= 64'd0;
      err_cnt_q   <= 16'd0;
    end else begin
      tready_q    <= 1'b1;
      ts_valid_q  <= good_s && (type_q == T_TS);
      std_valid_q <= good_s && (type_q == T_STD);
      ret_valid_q <= good_s && (type_q == T_RET);
      if (good_s) begin
        rx_ts_q <= cand_ts_d;
        rx_lt_q <= cand_lt_q;
      end
      if (bad_s && (err_cnt_q != 16'hFFFF)) begin
        err_cnt_q <= err_cnt_q + 16'd1;
      end
    end
  end

  assign o_rx_axis_tready = tready_q;
  assign o_ts_valid       = ts_valid_q;
  assign o_std_valid      = std_valid_q;
  assign o_return_valid   = ret_valid_q;
  assign o_rx_ts          = rx_ts_q;
  assign o_rx_local_time  = rx_lt_q;
  assign o_err_cnt        = err_cnt_q;

endmodule

// File: tb/tb_time_syn_rx.sv
// Self-checking bench for time_syn_rx: frame-level reference model compared every
// cycle, plus literal expectations for the directed scenarios.
module tb_time_syn_rx;
  localparam int P = 8;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic [63:0] lt = 64'd0;
  logic        tvalid = 1'b0;
  logic [63:0] tdata = 64'd0;
  logic        tlast = 1'b0;
  logic [7:0]  tkeep = 8'hFF;
  logic        tuser = 1'b0;
  logic        tready, ts_v, std_v, ret_v;
  logic [63:0] rx_ts, rx_lt;
  logic [15:0] err;

  int compared = 0;
  int mismatched = 0;
  int n_ts = 0, n_std = 0, n_ret = 0;

  time_syn_rx #(.P_FRAME_LEN(P)) dut (
    .i_clk(clk), .i_rst(rst), .i_local_time(lt),
    .i_rx_axis_tvalid(tvalid), .i_rx_axis_tdata(tdata), .i_rx_axis_tlast(tlast),
    .i_rx_axis_tkeep(tkeep), .i_rx_axis_tuser(tuser), .o_rx_axis_tready(tready),
    .o_ts_valid(ts_v), .o_std_valid(std_v), .o_return_valid(ret_v),
    .o_rx_ts(rx_ts), .o_rx_local_time(rx_lt), .o_err_cnt(err)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Frame-level reference model: collect a frame's beats, judge it at tlast
  typedef struct {logic [63:0] d; logic [7:0] k; logic [63:0] t;} beat_t;
  beat_t       fq[$];
  logic        m_ready;
  logic        e_ts, e_std, e_ret;
  logic [63:0] e_rx_ts, e_rx_lt;
  logic [15:0] e_err;

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      fq.delete();
      m_ready <= 1'b0; e_ts <= 1'b0; e_std <= 1'b0; e_ret <= 1'b0;
      e_rx_ts <= 64'd0; e_rx_lt <= 64'd0; e_err <= 16'd0;
    end else begin
      m_ready <= 1'b1;
      e_ts <= 1'b0; e_std <= 1'b0; e_ret <= 1'b0;
      if (tvalid && m_ready) begin
        beat_t b;
        logic good;
        b.d = tdata; b.k = tkeep; b.t = lt;
        fq.push_back(b);
        if (tlast) begin
          good = (fq.size() == P) && !tuser &&
                 (fq[0].d == 64'h66 || fq[0].d == 64'h88 || fq[0].d == 64'h55);
          foreach (fq[i]) if (fq[i].k != 8'hFF) good = 1'b0;
          if (good) begin
            e_ts  <= (fq[0].d == 64'h66);
            e_std <= (fq[0].d == 64'h88);
            e_ret <= (fq[0].d == 64'h55);
            e_rx_ts <= fq[1].d;
            e_rx_lt <= fq[0].t;
          end else if (e_err != 16'hFFFF) begin
            e_err <= e_err + 16'd1;
          end
          fq.delete();
        end
      end
    end
  end

  // Every-cycle comparison against the model, away from the active edge
  always @(negedge clk) begin
    chk("tready", {63'd0, tready}, {63'd0, m_ready});
    chk("ts_valid", {63'd0, ts_v}, {63'd0, e_ts});
    chk("std_valid", {63'd0, std_v}, {63'd0, e_std});
    chk("return_valid", {63'd0, ret_v}, {63'd0, e_ret});
    chk("rx_ts", rx_ts, e_rx_ts);
    chk("rx_local_time", rx_lt, e_rx_lt);
    chk("err_cnt", {48'd0, err}, {48'd0, e_err});
    if (ts_v) n_ts++;
    if (std_v) n_std++;
    if (ret_v) n_ret++;
  end

  task automatic beat(input logic [63:0] d, input logic last, input logic [7:0] k,
                      input logic u, input logic [63:0] t, input int bub);
    int gap;
    gap = (bub > 0) ? $urandom_range(0, bub) : 0;
    if (gap > 0) begin
      tvalid = 1'b0;
      repeat (gap) @(posedge clk);
      #1;
    end
    tdata = d; tlast = last; tkeep = k; tuser = u; lt = t; tvalid = 1'b1;
    @(posedge clk);
    #1;
  endtask

  task automatic send_frame(input logic [63:0] pre, input logic [63:0] ts, input int n,
                            input int bad_keep_beat, input logic u, input int bub,
                            input logic [63:0] lt0);
    logic [63:0] d;
    for (int i = 0; i < n; i++) begin
      if (i == 0) d = pre;
      else if (i == 1) d = ts;
      else d = {32'hA000_0000 | 32'($urandom_range(0, 65535)), 32'($urandom)};
      beat(d, (i == n - 1), (i == bad_keep_beat) ? 8'h0F : 8'hFF,
           (i == n - 1) ? u : 1'b0, lt0 + 64'(i), bub);
    end
    tvalid = 1'b0; tlast = 1'b0; tuser = 1'b0; tkeep = 8'hFF;
  endtask

  initial begin
    repeat (3) @(posedge clk);
    #1;
    chk("reset_tready", {63'd0, tready}, 64'd0);
    chk("reset_err", {48'd0, err}, 64'd0);
    rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("ready_after_release", {63'd0, tready}, 64'd1);

    // Good ts frame
    send_frame(64'h66, 64'h1234, 8, -1, 1'b0, 0, 64'h500);
    chk("ts_pulse", {63'd0, ts_v}, 64'd1);
    chk("ts_value", rx_ts, 64'h1234);
    chk("ts_local", rx_lt, 64'h500);
    chk("ts_err", {48'd0, err}, 64'd0);
    @(posedge clk); #1;
    chk("ts_pulse_one_cycle", {63'd0, ts_v}, 64'd0);

    // Back-to-back std then return frames with random bubbles
    send_frame(64'h88, 64'hAAAA_0001, 8, -1, 1'b0, 2, 64'h1000);
    send_frame(64'h55, 64'hBBBB_0002, 8, -1, 1'b0, 2, 64'h2000);
    chk("ret_pulse", {63'd0, ret_v}, 64'd1);
    chk("ret_value", rx_ts, 64'hBBBB_0002);
    chk("ret_local", rx_lt, 64'h2000);
    @(posedge clk); #1;
    chk("std_count", 64'(n_std), 64'd1);
    chk("ret_count", 64'(n_ret), 64'd1);

    // Unknown preamble, then a good frame
    send_frame(64'h77, 64'h9999, 8, -1, 1'b0, 0, 64'h3000);
    @(posedge clk); #1;
    chk("unknown_err", {48'd0, err}, 64'd1);
    send_frame(64'h66, 64'hC0DE, 8, -1, 1'b0, 1, 64'h4000);
    chk("after_unknown_value", rx_ts, 64'hC0DE);

    // Short (tlast on beat 5) and long (10 beats) frames
    send_frame(64'h88, 64'hDEAD, 6, -1, 1'b0, 0, 64'h5000);
    send_frame(64'h55, 64'hBEEF, 10, -1, 1'b0, 0, 64'h6000);
    @(posedge clk); #1;
    chk("length_err", {48'd0, err}, 64'd3);
    chk("length_ts_kept", rx_ts, 64'hC0DE);
    chk("length_lt_kept", rx_lt, 64'h4000);

    // tuser on last beat, then tkeep=0F on beat 3
    send_frame(64'h66, 64'h1111, 8, -1, 1'b1, 0, 64'h7000);
    @(posedge clk); #1;
    chk("tuser_err", {48'd0, err}, 64'd4);
    send_frame(64'h66, 64'h2222, 8, 3, 1'b0, 0, 64'h8000);
    @(posedge clk); #1;
    chk("tkeep_err", {48'd0, err}, 64'd5);
    chk("ts_pulse_total", 64'(n_ts), 64'd2);

    // Reset on beat 3, remainder after release, then a good frame
    beat(64'h66, 1'b0, 8'hFF, 1'b0, 64'h9000, 0);
    beat(64'h3333, 1'b0, 8'hFF, 1'b0, 64'h9001, 0);
    beat(64'h0102, 1'b0, 8'hFF, 1'b0, 64'h9002, 0);
    tdata = 64'h0103; rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    tvalid = 1'b0; rst = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    for (int i = 4; i < 8; i++) beat(64'hDEAD_0000 + 64'(i), (i == 7), 8'hFF, 1'b0, 64'h9000 + 64'(i), 0);
    tvalid = 1'b0; tlast = 1'b0;
    @(posedge clk); #1;
    chk("reset_partial_err", {48'd0, err}, 64'd1);
    chk("reset_partial_ts", rx_ts, 64'd0);
    send_frame(64'h88, 64'h4444, 8, -1, 1'b0, 0, 64'hA000);
    chk("post_reset_std", {63'd0, std_v}, 64'd1);
    chk("post_reset_ts", rx_ts, 64'h4444);

    // Saturation: 65537 one-beat bad frames
    tdata = 64'd0; tkeep = 8'hFF; tlast = 1'b1; tvalid = 1'b1;
    repeat (65537) @(posedge clk);
    #1;
    tvalid = 1'b0; tlast = 1'b0;
    @(posedge clk); #1;
    chk("err_saturated", {48'd0, err}, 64'hFFFF);
    send_frame(64'h77, 64'h0, 8, -1, 1'b0, 0, 64'h0);
    @(posedge clk); #1;
    chk("err_stays_saturated", {48'd0, err}, 64'hFFFF);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end
endmodule
